// File: rtl/bus_arbiter.sv
// bus_arbiter: grants one of NumReq requesters access to a single shared memory port, with
// at most one transaction outstanding (IDLE -> ISSUE -> WAIT_RSP -> IDLE).
// Optional feature: define BUS_ARB_ROUND_ROBIN_EN for round-robin arbitration with a rotating
// priority pointer; leave it undefined for fixed priority (lowest index wins).
module bus_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumReq-1:0]    req_valid_i,
  output logic [NumReq-1:0]    req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i  [NumReq],
  input  logic [DataWidth-1:0] req_wdata_i [NumReq],
  input  logic                 req_we_i    [NumReq],
  output logic [NumReq-1:0]    rsp_valid_o,
  output logic [DataWidth-1:0] rsp_rdata_o [NumReq],
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic                 mem_we_o,
  input  logic                 mem_rsp_valid_i,
  input  logic [DataWidth-1:0] mem_rsp_rdata_i,
  output logic [$clog2(NumReq)-1:0] grant_idx_o,
  output logic                 busy_o
);

  localparam int unsigned IdxWidth = $clog2(NumReq);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [IdxWidth-1:0] r_grant;
  logic [IdxWidth-1:0] w_winner;
  logic                w_any_valid;
  logic                w_rsp_done;

  assign w_any_valid = |req_valid_i;
  // A response only counts while a transaction is actually waiting for it.
  assign w_rsp_done  = (r_state == StWaitRsp) && mem_rsp_valid_i;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [IdxWidth-1:0] r_ptr;

  // Winner: first valid requester scanning upward from the pointer, wrapping around.
  always_comb begin : p_pick_rr
    int unsigned idx;
    logic        found;
    idx      = 0;
    found    = 1'b0;
    w_winner = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = (32'(r_ptr) + k) % NumReq;
      if (!found && req_valid_i[IdxWidth'(idx)]) begin
        w_winner = IdxWidth'(idx);
        found    = 1'b1;
      end
    end
  end

  // Pointer moves just past the owner each time a transaction completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_rsp_done) begin
      r_ptr <= (32'(r_grant) == NumReq - 1) ? '0 : r_grant + IdxWidth'(1);
    end
  end
`else
  // Winner: lowest-index valid requester (scan downward so the lowest index is written last).
  always_comb begin
    w_winner = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req_valid_i[IdxWidth'(i)]) begin
        w_winner = IdxWidth'(i);
      end
    end
  end
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Grant is captured only in IDLE, so late requests wait for the next arbitration round.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_grant <= '0;
    end else if ((r_state == StIdle) && w_any_valid) begin
      r_grant <= w_winner;
    end
  end

  // Next-state and datapath routing; every lane is zero unless it is the owner.
  always_comb begin
    w_state_next    = r_state;
    mem_req_valid_o = 1'b0;
    mem_addr_o      = '0;
    mem_wdata_o     = '0;
    mem_we_o        = 1'b0;
    req_ready_o     = '0;
    rsp_valid_o     = '0;
    for (int i = 0; i < NumReq; i++) begin
      rsp_rdata_o[i] = '0;
    end

    unique case (r_state)
      StIdle: begin
        if (w_any_valid) begin
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = req_addr_i[r_grant];
        mem_wdata_o     = req_wdata_i[r_grant];
        mem_we_o        = req_we_i[r_grant];
        for (int i = 0; i < NumReq; i++) begin
          if (IdxWidth'(i) == r_grant) begin
            req_ready_o[i] = mem_req_ready_i;
          end
        end
        if (mem_req_ready_i) begin
          w_state_next = StWaitRsp;
        end
      end
      StWaitRsp: begin
        if (mem_rsp_valid_i) begin
          for (int i = 0; i < NumReq; i++) begin
            if (IdxWidth'(i) == r_grant) begin
              rsp_valid_o[i] = 1'b1;
              rsp_rdata_o[i] = mem_rsp_rdata_i;
            end
          end
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign grant_idx_o = r_grant;
  assign busy_o      = (r_state != StIdle);

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 4: number of requesters; legal range 2..16.
REQ-002 SHALL have parameter AddrWidth, default 32: request address width.
REQ-003 SHALL have parameter DataWidth, default 32: write and read data width.
REQ-004 SHALL derive localparam IdxWidth = $clog2(NumReq).
REQ-005 SHALL have port clk_i  in  1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i  in  1: asynchronous reset, active-high.
REQ-007 SHALL have port req_valid_i  in  [NumReq]: requester i has a pending request.
REQ-008 SHALL have port req_ready_o  out  [NumReq]: request i accepted this cycle.
REQ-009 SHALL have ports req_addr_i [AddrWidth], req_wdata_i [DataWidth] and req_we_i [1], each  in  and unpacked [NumReq]: per-requester address, write data and write enable.
REQ-010 SHALL have port rsp_valid_o  out  [NumReq]: one-cycle response strobe to requester i.
REQ-011 SHALL have port rsp_rdata_o  out  [DataWidth] x [NumReq]: read data routed to requester i.
REQ-012 SHALL have ports mem_req_valid_o  out  1, mem_req_ready_i  in  1, mem_addr_o  out  AddrWidth, mem_wdata_o  out  DataWidth and mem_we_o  out  1: request channel to the shared memory port.
REQ-013 SHALL have ports mem_rsp_valid_i  in  1 and mem_rsp_rdata_i  in  DataWidth: response channel from the memory port.
REQ-014 SHALL have ports grant_idx_o  out  IdxWidth and busy_o  out  1: current owner index and transaction-in-flight flag.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE and WAIT_RSP, with at most one transaction outstanding.
REQ-016 IDLE: if any req_valid_i is set, SHALL register the winner into grant_idx and move to ISSUE next cycle; otherwise SHALL stay in IDLE.
REQ-017 ISSUE: mem_req_valid_o=1; mem_addr_o, mem_wdata_o and mem_we_o SHALL be combinationally muxed from requester grant_idx; req_ready_o[grant_idx]=mem_req_ready_i; all other req_ready_o bits 0.
REQ-018 ISSUE: on mem_req_valid_o && mem_req_ready_i, SHALL move to WAIT_RSP; otherwise SHALL hold ISSUE with the grant unchanged, even if the granted requester drops valid (protocol violation, not recovered).
REQ-019 WAIT_RSP: on mem_rsp_valid_i, rsp_valid_o[grant_idx]=1 and rsp_rdata_o[grant_idx]=mem_rsp_rdata_i for that same cycle; all other lanes SHALL be 0 valid and 0 data; SHALL then move to IDLE.
REQ-020 Writes SHALL also complete via mem_rsp_valid_i (acknowledge); the rdata value is passed through unchanged.
REQ-021 mem_rsp_valid_i SHALL be ignored outside WAIT_RSP.
REQ-022 rsp_valid_o and rsp_rdata_o SHALL be 0 on all lanes whenever no response is being delivered.
REQ-023 busy_o SHALL be 1 in ISSUE and WAIT_RSP, 0 in IDLE; grant_idx_o SHALL show the registered grant in all states.
REQ-024 Minimum transaction time SHALL be 3 cycles (IDLE->ISSUE->WAIT_RSP->IDLE) with zero-wait memory; back-to-back grants SHALL be issued with no extra idle cycle beyond IDLE.
REQ-025 Arbitration SHALL be decided only in IDLE; requests that arrive later SHALL wait without being lost as long as valid is held.

Reset
REQ-026 While rst_i=1: state=IDLE, grant_idx=0, priority pointer=0; all outputs 0 (req_ready_o, rsp_valid_o, rsp_rdata_o, mem_req_valid_o, mem_addr_o, mem_wdata_o, mem_we_o, busy_o, grant_idx_o).
REQ-027 Reset asserted mid-transaction SHALL abandon it: no rsp_valid_o for it, and arbitration restarts from IDLE with pointer 0.

Configuration
REQ-028 Macro BUS_ARB_ROUND_ROBIN_EN defined: the winner SHALL be the first valid requester scanning upward, with wrap-around, from the pointer; on each response the pointer SHALL be set to (grant_idx+1) mod NumReq.
REQ-029 Macro BUS_ARB_ROUND_ROBIN_EN undefined: fixed priority SHALL apply, lowest index wins, and no pointer register SHALL exist.

Verification
REQ-030 Reset then req_valid_i=4'b0100, ready=1, rsp after 1 cycle with rdata=32'hDEAD_BEEF -> grant_idx_o=2, req_ready_o[2] pulses in ISSUE, rsp_valid_o=4'b0100 with rdata lane 2=DEAD_BEEF, done in 3 cycles.
REQ-031 RR build, all four valid held for 4 transactions -> grant order 0,1,2,3; a fifth transaction grants 0 (wrap).
REQ-032 Fixed build, all four valid held -> every grant is 0; after req 0 drops, the next grant is 1.
REQ-033 mem_req_ready_i held low 5 cycles in ISSUE with req 3 granted and req 1 newly valid -> grant stays 3, mem outputs stable, req_ready_o all 0 until ready rises.
REQ-034 rst_i pulsed during WAIT_RSP for granted req 1, then mem_rsp_valid_i=1 -> no rsp_valid_o, all outputs 0, busy_o=0.
REQ-035 mem_rsp_valid_i=1 while in IDLE with no valids -> rsp_valid_o stays 4'b0000 and state stays IDLE.
